// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared states, default timings and counter sizing for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAIL       = 3'd4
  } pll_state_e;

  localparam int DEF_RST_CYCLES    = 100;
  localparam int DEF_LOCK_TIMEOUT  = 100000;
  localparam int DEF_STABLE_CYCLES = 1000;
  localparam int DEF_MAX_RETRIES   = 4;

  // One shared counter has to reach the largest of the three phase lengths;
  // the extra bit keeps the terminal compares clear of wrap-around.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous status inputs
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  // Each stage takes the previous one; the first stage absorbs metastability.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Both stages clear together so no stale status survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - IOPLL reset/lock sequencer driving the PLL and core reset tree
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       req_relock,
  output logic       pll_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRIES);

  pll_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, pll_rst_d;
  logic          core_rst_q, core_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          lock_s;
  logic [3:0]    retry_inc;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign retry_inc = retry_q + 4'd1;

  // Next state, shared counter, retry/loss bookkeeping and registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    // A lock drop in RUN is counted even when a relock request lands on the same edge.
    if (state_q == RUN && !lock_s && loss_q != 8'hFF) begin
      loss_d = loss_q + 8'd1;
    end

    if (req_relock) begin
      state_d = RESET_HOLD;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_HOLD: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
            cnt_d   = CNT_ONE;
          end else if (cnt_q == LOCK_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_MAX) ? FAIL : RESET_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q >= STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d = RESET_HOLD;
            cnt_d   = '0;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs follow the next state so they switch on the same edge as the state.
    pll_rst_d  = (state_d == RESET_HOLD) || (state_d == FAIL);
    core_rst_d = (state_d != RUN);
    ready_d    = (state_d == RUN);
    fail_d     = (state_d == FAIL);
  end

  // Sequencer state register; reset parks everything in the held-off condition.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= RESET_HOLD;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_rst_q  <= pll_rst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign core_rst  = core_rst_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for the PLL lock sequencer
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 16;
  localparam int MAX_RETRIES   = 3;

  localparam int M_HOLD = 0, M_WAIT = 1, M_SETTLE = 2, M_RUN = 3, M_DEAD = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       req_relock = 1'b0;
  logic       pll_rst, core_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int m_ph = M_HOLD, m_dwell = 0, m_retries = 0, m_losses = 0;
  bit m_sync0 = 1'b0, m_sync1 = 1'b0;
  logic [15:0] exp_q[$];

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .req_relock(req_relock),
    .pll_rst(pll_rst), .core_rst(core_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_vec();
    return {(m_ph == M_HOLD || m_ph == M_DEAD), (m_ph != M_RUN), (m_ph == M_RUN),
            (m_ph == M_DEAD), 4'(m_retries), 8'(m_losses)};
  endfunction

  // Reference model: phase rules applied once per reference-clock edge.
  initial forever begin
    bit lock_seen;
    @(posedge refclk or posedge rst);
    if (rst) begin
      m_ph = M_HOLD; m_dwell = 0; m_retries = 0; m_losses = 0;
      m_sync0 = 1'b0; m_sync1 = 1'b0;
      exp_q.delete();
    end else begin
      lock_seen = m_sync1;
      m_sync1 = m_sync0;
      m_sync0 = pll_locked;
      if (req_relock) begin
        if (m_ph == M_RUN && !lock_seen && m_losses < 255) m_losses++;
        m_ph = M_HOLD; m_dwell = 0; m_retries = 0;
      end else begin
        case (m_ph)
          M_HOLD: begin
            m_dwell++;
            if (m_dwell == RST_CYCLES) begin m_ph = M_WAIT; m_dwell = 0; end
          end
          M_WAIT: begin
            if (lock_seen) begin
              m_ph = M_SETTLE; m_dwell = 1;
            end else begin
              m_dwell++;
              if (m_dwell == LOCK_TIMEOUT) begin
                m_retries++;
                m_dwell = 0;
                m_ph = (m_retries == MAX_RETRIES) ? M_DEAD : M_HOLD;
              end
            end
          end
          M_SETTLE: begin
            if (!lock_seen) begin
              m_ph = M_WAIT; m_dwell = 0;
            end else begin
              m_dwell++;
              if (m_dwell >= STABLE_CYCLES) begin m_ph = M_RUN; m_dwell = 0; m_retries = 0; end
            end
          end
          M_RUN: begin
            if (!lock_seen) begin
              m_ph = M_HOLD; m_dwell = 0;
              if (m_losses < 255) m_losses++;
            end
          end
          default: ;
        endcase
      end
    end
    exp_q.push_back(model_vec());
  end

  // Monitor: compares the DUT outputs against the oldest queued expectation.
  initial forever begin
    logic [15:0] e;
    @(negedge refclk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("outputs{pll_rst,core_rst,ready,fail,retry,loss}",
          {16'd0, pll_rst, core_rst, ready, fail, retry_cnt, loss_cnt}, {16'd0, e});
    end
    chk("pll_rst_and_ready", {31'd0, pll_rst & ready}, 32'd0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return pll_rst;
      1: return ready;
      2: return fail;
      default: return core_rst;
    endcase
  endfunction

  // Counts edges until the selected output reaches val, giving up after bound.
  task automatic edges_until(input int sel, input logic val, input int bound, output int n);
    n = 0;
    do begin
      @(posedge refclk); #1; n++;
    end while (sig(sel) !== val && n < bound);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pll_rst"}, {31'd0, pll_rst}, 32'd1);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    chk({tag, "_ready"}, {31'd0, ready}, 32'd0);
    chk({tag, "_fail"}, {31'd0, fail}, 32'd0);
    chk({tag, "_retry"}, {28'd0, retry_cnt}, 32'd0);
    chk({tag, "_loss"}, {24'd0, loss_cnt}, 32'd0);
  endtask

  // Asserts rst between clock edges and checks the outputs respond without an edge.
  task automatic async_rst(input bit do_check, input string tag);
    @(posedge refclk); #2;
    rst = 1'b1;
    #1;
    if (do_check) check_reset_outputs(tag);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic relock_pulse();
    @(negedge refclk); req_relock = 1'b1;
    @(negedge refclk); req_relock = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge refclk);
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // 1: nominal bring-up
    edges_until(0, 1'b0, 20, n);
    chk("t1_hold_cycles", n, RST_CYCLES);
    repeat (6) @(negedge refclk);
    pll_locked = 1'b1;
    edges_until(1, 1'b1, 100, n);
    chk("t1_lock_to_run_edges", n, STABLE_CYCLES + 2);
    chk("t1_core_rst", {31'd0, core_rst}, 32'd0);
    chk("t1_retry", {28'd0, retry_cnt}, 32'd0);

    // 2: no lock at all -> three timeouts then FAIL, relock recovers
    @(negedge refclk); pll_locked = 1'b0;
    async_rst(1'b0, "t2");
    edges_until(2, 1'b1, 400, n);
    chk("t2_edges_to_fail", n, MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT));
    chk("t2_fail_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("t2_fail_retry", {28'd0, retry_cnt}, MAX_RETRIES);
    @(negedge refclk); req_relock = 1'b1;
    @(posedge refclk); #1;
    chk("t2_relock_fail", {31'd0, fail}, 32'd0);
    chk("t2_relock_retry", {28'd0, retry_cnt}, 32'd0);
    chk("t2_relock_pll_rst", {31'd0, pll_rst}, 32'd1);
    @(negedge refclk); req_relock = 1'b0;

    // 3: one-cycle lock glitch during STABLE
    edges_until(0, 1'b0, 20, n);
    @(negedge refclk); pll_locked = 1'b1;
    repeat (12) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk); pll_locked = 1'b1;
    edges_until(1, 1'b1, 100, n);
    chk("t3_rerise_to_run_edges", n, STABLE_CYCLES + 2);

    // 4: loss of lock in RUN, then saturate the loss counter
    @(negedge refclk); pll_locked = 1'b0;
    edges_until(1, 1'b0, 10, n);
    chk("t4_drop_to_reset_edges", n, 3);
    chk("t4_core_rst", {31'd0, core_rst}, 32'd1);
    chk("t4_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("t4_loss_one", {24'd0, loss_cnt}, 32'd1);
    for (int i = 0; i < 299; i++) begin
      @(negedge refclk); pll_locked = 1'b1;
      edges_until(1, 1'b1, 100, n);
      chk("t4_reach_run", {31'd0, ready}, 32'd1);
      @(negedge refclk); pll_locked = 1'b0;
      edges_until(1, 1'b0, 10, n);
      chk("t4_leave_run", {31'd0, ready}, 32'd0);
    end
    chk("t4_loss_saturated", {24'd0, loss_cnt}, 32'd255);

    // 5a: relock on the same edge as a WAIT_LOCK timeout
    async_rst(1'b0, "t5");
    n = 0;
    do begin @(negedge refclk); n++; end
    while (!(m_ph == M_WAIT && m_dwell == LOCK_TIMEOUT - 1 && m_retries == 1) && n < 500);
    chk("t5_timeout_edge_found", {31'd0, n < 500}, 32'd1);
    req_relock = 1'b1;
    @(posedge refclk); #1;
    chk("t5_relock_retry", {28'd0, retry_cnt}, 32'd0);
    chk("t5_relock_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("t5_relock_fail", {31'd0, fail}, 32'd0);
    @(negedge refclk); req_relock = 1'b0;

    // 5b: relock coinciding with a lock drop in RUN
    pll_locked = 1'b1;
    edges_until(1, 1'b1, 100, n);
    chk("t5_reach_run", {31'd0, ready}, 32'd1);
    @(negedge refclk); pll_locked = 1'b0;
    @(posedge refclk); @(posedge refclk);
    @(negedge refclk); req_relock = 1'b1;
    @(posedge refclk); #1;
    chk("t5_drop_relock_loss", {24'd0, loss_cnt}, 32'd1);
    chk("t5_drop_relock_ready", {31'd0, ready}, 32'd0);
    @(negedge refclk); req_relock = 1'b0;

    // 6: async reset mid-STABLE and mid-RUN, then restart with lock held
    pll_locked = 1'b1;
    edges_until(0, 1'b0, 20, n);
    repeat (8) @(negedge refclk);
    async_rst(1'b1, "t6_stable");
    edges_until(1, 1'b1, 100, n);
    chk("t6_restart_after_stable", n, RST_CYCLES + STABLE_CYCLES);
    repeat (5) @(negedge refclk);
    async_rst(1'b1, "t6_run");
    edges_until(1, 1'b1, 100, n);
    chk("t6_restart_after_run", n, RST_CYCLES + STABLE_CYCLES);

    // Randomized traffic checked by the scoreboard
    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        async_rst(1'b1, "rnd_rst");
      end else begin
        int len;
        @(negedge refclk);
        pll_locked = 1'($urandom_range(0, 1));
        len = pll_locked ? $urandom_range(1, 40) : $urandom_range(1, 250);
        for (int c = 0; c < len; c++) begin
          req_relock = (r <= 2) ? ($urandom_range(0, 49) == 0) : 1'b0;
          @(negedge refclk);
        end
        req_relock = 1'b0;
      end
    end

    repeat (4) @(negedge refclk);
    chk("scoreboard_drained", {31'd0, exp_q.size() <= 1}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
